// File: rtl/recon_pkg.sv
// Shared definitions for the reconfiguration descriptor scheduler: FSM encodings
// and DMA status error codes.
package recon_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam logic [3:0] DMA_ERR_NONE      = 4'h0;
  localparam logic [3:0] DMA_ERR_TIMEOUT   = 4'h1;
  localparam logic [3:0] DMA_ERR_PARITY    = 4'h2;
  localparam logic [3:0] DMA_ERR_DECODE    = 4'h3;
  localparam logic [3:0] DMA_ERR_SLAVE     = 4'h4;
  localparam logic [3:0] DMA_ERR_LEN       = 4'h5;

endpackage

// File: rtl/recon_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the lowest requesting index at or above
// rr_ptr, wrapping to the lowest requesting index below it.
module recon_rr_arbiter #(
  parameter int PORTS = 2,
  parameter int PTR_W = 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PORTS-1:0] grant
);

  logic found;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (!found && req[p] && (p >= int'(rr_ptr))) begin
        grant[p] = 1'b1;
        found    = 1'b1;
      end
    end
    // Nothing at or above the pointer: the lowest requester overall is the wrap winner.
    for (int p = 0; p < PORTS; p++) begin
      if (!found && req[p]) begin
        grant[p] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/recon_desc_scheduler.sv
// Shares one DMA read-descriptor channel between PORTS requesters, tagging each
// issued descriptor with a slot index and routing completions back to the owner.
module recon_desc_scheduler
  import recon_pkg::*;
#(
  parameter int PORTS              = 2,
  parameter int ADDR_WIDTH         = 34,
  parameter int DMA_DESC_LEN_WIDTH = 20,
  parameter int DMA_DESC_TAG_WIDTH = 8,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,

  input  logic [PORTS*ADDR_WIDTH-1:0]           s_axis_req_addr,
  input  logic [PORTS*DMA_DESC_LEN_WIDTH-1:0]   s_axis_req_len,
  input  logic [PORTS*DMA_DESC_TAG_WIDTH-1:0]   s_axis_req_tag,
  input  logic [PORTS-1:0]                      s_axis_req_valid,
  output logic [PORTS-1:0]                      s_axis_req_ready,

  output logic [ADDR_WIDTH-1:0]                 m_axis_read_desc_addr,
  output logic [DMA_DESC_LEN_WIDTH-1:0]         m_axis_read_desc_len,
  output logic [DMA_DESC_TAG_WIDTH-1:0]         m_axis_read_desc_tag,
  output logic                                  m_axis_read_desc_valid,
  input  logic                                  m_axis_read_desc_ready,

  input  logic [DMA_DESC_TAG_WIDTH-1:0]         s_axis_read_desc_status_tag,
  input  logic [3:0]                            s_axis_read_desc_status_error,
  input  logic                                  s_axis_read_desc_status_valid,

  output logic [PORTS*DMA_DESC_TAG_WIDTH-1:0]   m_axis_status_tag,
  output logic [PORTS*4-1:0]                    m_axis_status_error,
  output logic [PORTS-1:0]                      m_axis_status_valid,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_count,
  output logic                                  stat_unknown_tag
);

  localparam int PTR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING+1);

  logic [0:0]                    state;
  logic [PTR_W-1:0]              rr_ptr;
  logic [MAX_OUTSTANDING-1:0]    occ;
  logic [PTR_W-1:0]              slot_port [MAX_OUTSTANDING];
  logic [DMA_DESC_TAG_WIDTH-1:0] slot_tag  [MAX_OUTSTANDING];
  logic [CNT_W-1:0]              count;

  logic [PORTS-1:0]              req_vec;
  logic [PORTS-1:0]              grant;
  logic                          accept;
  logic [PTR_W-1:0]              win_idx;
  logic [PTR_W-1:0]              next_ptr;
  logic [ADDR_WIDTH-1:0]         win_addr;
  logic [DMA_DESC_LEN_WIDTH-1:0] win_len;
  logic [DMA_DESC_TAG_WIDTH-1:0] win_tag;
  logic                          free_exists;
  logic [SLOT_W-1:0]             free_idx;
  logic                          st_in_range;
  logic [SLOT_W-1:0]             st_slot;
  logic                          st_hit;
  logic [PTR_W-1:0]              st_port;

  // Offers are only made while idle, out of reset, with a slot to allocate into.
  assign req_vec = (!rst && state == ST_IDLE && free_exists) ? s_axis_req_valid : '0;

  recon_rr_arbiter #(
    .PORTS (PORTS),
    .PTR_W (PTR_W)
  ) u_arb (
    .req    (req_vec),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  assign s_axis_req_ready = grant;
  assign accept           = |grant;
  assign next_ptr         = (win_idx == PTR_W'(PORTS-1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_len  = '0;
    win_tag  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant[p]) begin
        win_idx  = PTR_W'(p);
        win_addr = s_axis_req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = s_axis_req_len[p*DMA_DESC_LEN_WIDTH +: DMA_DESC_LEN_WIDTH];
        win_tag  = s_axis_req_tag[p*DMA_DESC_TAG_WIDTH +: DMA_DESC_TAG_WIDTH];
      end
    end
  end

  // Descending scan leaves the lowest free index as the final assignment.
  always_comb begin
    free_exists = 1'b0;
    free_idx    = '0;
    for (int s = MAX_OUTSTANDING-1; s >= 0; s--) begin
      if (!occ[s]) begin
        free_exists = 1'b1;
        free_idx    = SLOT_W'(s);
      end
    end
  end

  assign st_in_range = int'(s_axis_read_desc_status_tag) < MAX_OUTSTANDING;
  assign st_slot     = s_axis_read_desc_status_tag[SLOT_W-1:0];
  assign st_hit      = s_axis_read_desc_status_valid && st_in_range && occ[st_slot];
  assign st_port     = slot_port[st_slot];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= ST_IDLE;
      rr_ptr                 <= '0;
      occ                    <= '0;
      count                  <= '0;
      stat_unknown_tag       <= 1'b0;
      m_axis_read_desc_addr  <= '0;
      m_axis_read_desc_len   <= '0;
      m_axis_read_desc_tag   <= '0;
      m_axis_read_desc_valid <= 1'b0;
      m_axis_status_tag      <= '0;
      m_axis_status_error    <= '0;
      m_axis_status_valid    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            m_axis_read_desc_addr  <= win_addr;
            m_axis_read_desc_len   <= win_len;
            m_axis_read_desc_tag   <= DMA_DESC_TAG_WIDTH'(free_idx);
            m_axis_read_desc_valid <= 1'b1;
            rr_ptr                 <= next_ptr;
            state                  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_axis_read_desc_ready) begin
            m_axis_read_desc_valid <= 1'b0;
            state                  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Alloc and free never target the same slot: alloc picks a free one, free needs an occupied one.
      if (st_hit) occ[st_slot]  <= 1'b0;
      if (accept) occ[free_idx] <= 1'b1;
      count <= count + CNT_W'(accept) - CNT_W'(st_hit);

      m_axis_status_valid <= '0;
      for (int p = 0; p < PORTS; p++) begin
        if (st_hit && st_port == PTR_W'(p)) begin
          m_axis_status_valid[p]                                        <= 1'b1;
          m_axis_status_tag[p*DMA_DESC_TAG_WIDTH +: DMA_DESC_TAG_WIDTH] <= slot_tag[st_slot];
          m_axis_status_error[p*4 +: 4]                                 <= s_axis_read_desc_status_error;
        end
      end

      if (s_axis_read_desc_status_valid && !st_hit) stat_unknown_tag <= 1'b1;
    end
  end

  // NOTE: slot payload needs no reset; occ gates every read of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_port[free_idx] <= win_idx;
      slot_tag[free_idx]  <= win_tag;
    end
  end

  assign outstanding_count = count;

endmodule

// File: doc/recon_desc_scheduler.md
RECON_DESC_SCHEDULER -- requirements
Module: recon_desc_scheduler

Interface
REQ-001 Parameter PORTS, default 2: number of requesters sharing one DMA read-descriptor channel.
REQ-002 Parameter ADDR_WIDTH, default 34: descriptor address width.
REQ-003 Parameter DMA_DESC_LEN_WIDTH, default 20: descriptor length width.
REQ-004 Parameter DMA_DESC_TAG_WIDTH, default 8: tag width, requester side and DMA side.
REQ-005 Parameter MAX_OUTSTANDING, default 4: slot-table depth; must satisfy clog2(MAX_OUTSTANDING) <= DMA_DESC_TAG_WIDTH.
REQ-006 Port clk  input  1: the single clock.
REQ-007 Port rst  input  1: reset, synchronous and active-high.
REQ-008 Port s_axis_req_addr  input  PORTS*ADDR_WIDTH: per-port request address.
REQ-009 Port s_axis_req_len  input  PORTS*DMA_DESC_LEN_WIDTH: per-port request length.
REQ-010 Port s_axis_req_tag  input  PORTS*DMA_DESC_TAG_WIDTH: per-port requester tag.
REQ-011 Port s_axis_req_valid  input  PORTS: per-port request valid.
REQ-012 Port s_axis_req_ready  output  PORTS: per-port accept, one-hot or zero.
REQ-013 Port m_axis_read_desc_addr  output  ADDR_WIDTH: issued address.
REQ-014 Port m_axis_read_desc_len  output  DMA_DESC_LEN_WIDTH: issued length.
REQ-015 Port m_axis_read_desc_tag  output  DMA_DESC_TAG_WIDTH: slot index, zero-extended.
REQ-016 Port m_axis_read_desc_valid  output  1 / m_axis_read_desc_ready  input  1: DMA descriptor handshake.
REQ-017 Port s_axis_read_desc_status_tag  input  DMA_DESC_TAG_WIDTH / _error  input  4 / _valid  input  1: DMA completion, no backpressure.
REQ-018 Port m_axis_status_tag  output  PORTS*DMA_DESC_TAG_WIDTH / m_axis_status_error  output  PORTS*4 / m_axis_status_valid  output  PORTS: per-port completion return.
REQ-019 Port outstanding_count  output  clog2(MAX_OUTSTANDING+1): occupied slots.
REQ-020 Port stat_unknown_tag  output  1: sticky; set by a status for an unoccupied slot.

Function
REQ-021 States: IDLE, ISSUE.
REQ-022 IDLE: if any request is valid and a free slot exists, ready SHALL be asserted combinationally, in that cycle, for the round-robin winner only.
- Grant: lowest port index >= rr_ptr, wrapping.
- On grant: rr_ptr becomes winner+1 mod PORTS.
- Allocation: lowest-index free slot, storing {port, requester tag}.
- Next state: ISSUE.
REQ-023 ISSUE: the registered descriptor SHALL be presented with valid high and held stable until ready; on ready, next state is IDLE.
- Sustained throughput: one descriptor per 2 cycles.
REQ-024 Table full: ready SHALL stay 0 for all ports; no grant.
REQ-025 Status handling:
- On status_valid with tag < MAX_OUTSTANDING and that slot occupied, the stored port SHALL see a registered 1-cycle status_valid pulse, one cycle after input.
- The pulse carries the stored requester tag and the DMA error code.
- The slot frees in the same update.
REQ-026 Status for an unoccupied or out-of-range slot SHALL be dropped, set stat_unknown_tag, and change no table state.
REQ-027 Allocation and free in the same cycle SHALL both take effect.
- A slot freed in cycle t is allocatable from cycle t+1.
- outstanding_count changes by the net of the two events.
REQ-028 m_axis_status_valid SHALL be zero on all ports except the one returning a status.

Reset
REQ-029 On rst:
- state IDLE, rr_ptr 0, all slots free, outstanding_count 0, stat_unknown_tag 0.
- All valid/ready outputs 0; all data outputs 0.
REQ-030 Reset mid-ISSUE SHALL drop the pending descriptor (valid low the next cycle).
REQ-031 Statuses arriving after reset for pre-reset slots SHALL be treated as unknown tags.

Structure
REQ-032 State encodings and status error-code constants SHALL live in shared package recon_pkg.
REQ-033 Round-robin selection SHALL be sub-module recon_rr_arbiter (inputs request vector, rr_ptr; output one-hot grant).

Verification
REQ-034 Bench SHALL cover these scenarios.
- Single request: port0, addr 0x1000, len 0x400, tag 0x5A, DMA ready high -> descriptor valid 1 cycle after accept, tag 0, outstanding_count 1; status tag 0, error 0 -> port0 status tag 0x5A, outstanding_count 0.
- Fairness: both ports valid continuously -> grants alternate 0,1,0,1.
- Backpressure: DMA ready low 10 cycles -> descriptor stable; no new accept while ISSUE.
- Table full: 4 unanswered requests -> fifth request not accepted; status tag 2 -> fifth accepted next grant, allocated to slot 2.
- Unknown tag: status tag 7 -> no port pulse, stat_unknown_tag stays 1 until reset.
- Reset during ISSUE -> descriptor valid low next cycle; outstanding_count 0.
